trivium_keystream_gen: RTL and testbench

TRIVIUM_KEYSTREAM_GEN -- requirements
Module: trivium_keystream_gen

---
 rtl/trivium_pkg.sv | 35 +++
 rtl/trivium_step.sv | 26 ++
 rtl/trivium_keystream_gen.sv | 129 ++++++++++++
 tb/tb_trivium_keystream_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared constants for the Trivium keystream generator: register geometry, tap
// positions, default warm-up length and the controller state encoding.
package trivium_pkg;

  localparam int unsigned ALen = 93;
  localparam int unsigned BLen = 84;
  localparam int unsigned CLen = 111;
  localparam int unsigned KeyLen = 80;
  localparam int unsigned DefaultWarmupBits = 1152;

  // Linear output taps; the last cell of each register is the other output term.
  localparam int unsigned AOutTap = 65;
  localparam int unsigned BOutTap = 68;
  localparam int unsigned COutTap = 65;

  // AND-pair taps, read from the register feeding the next one in the ring.
  localparam int unsigned AAndTap0 = 90;
  localparam int unsigned AAndTap1 = 91;
  localparam int unsigned BAndTap0 = 81;
  localparam int unsigned BAndTap1 = 82;
  localparam int unsigned CAndTap0 = 108;
  localparam int unsigned CAndTap1 = 109;

  // Feedback taps, read from the register receiving the new bit.
  localparam int unsigned AFbTap = 68;
  localparam int unsigned BFbTap = 77;
  localparam int unsigned CFbTap = 86;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun
  } state_e;

endpackage

// File: rtl/trivium_step.sv
// One combinational Trivium bit-step: produces z from the current state and the
// state shifted by one position (bit 0 is the shift-in end).
module trivium_step
  import trivium_pkg::*;
(
  input  logic [ALen-1:0] a_i,
  input  logic [BLen-1:0] b_i,
  input  logic [CLen-1:0] c_i,
  output logic [ALen-1:0] a_o,
  output logic [BLen-1:0] b_o,
  output logic [CLen-1:0] c_o,
  output logic            z_o
);

  logic t1, t2, t3;

  assign t1  = a_i[AOutTap] ^ a_i[ALen-1];
  assign t2  = b_i[BOutTap] ^ b_i[BLen-1];
  assign t3  = c_i[COutTap] ^ c_i[CLen-1];
  assign z_o = t1 ^ t2 ^ t3;

  assign a_o = {a_i[ALen-2:0], t3 ^ (c_i[CAndTap0] & c_i[CAndTap1]) ^ a_i[AFbTap]};
  assign b_o = {b_i[BLen-2:0], t1 ^ (a_i[AAndTap0] & a_i[AAndTap1]) ^ b_i[BFbTap]};
  assign c_o = {c_i[CLen-2:0], t2 ^ (b_i[BAndTap0] & b_i[BAndTap1]) ^ c_i[CFbTap]};

endmodule

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator producing W bits per advancing cycle, with a
// load/warm-up/run controller and a valid/ready output register.
module trivium_keystream_gen
  import trivium_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned WARMUP_BITS = DefaultWarmupBits
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [KeyLen-1:0] key,
  input  logic [KeyLen-1:0] iv,
  output logic              busy,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [W-1:0]      ks_data
);

  localparam int unsigned WarmupCycles = WARMUP_BITS / W;
  localparam int unsigned CntW = $clog2(WarmupCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WarmupCycles - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  state_e            state_q, state_d;
  logic [ALen-1:0]   a_q, a_d, a_adv;
  logic [BLen-1:0]   b_q, b_d, b_adv;
  logic [CLen-1:0]   c_q, c_d, c_adv;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ks_valid_q, ks_valid_d;
  logic [W-1:0]      ks_data_q, ks_data_d;
  logic [W-1:0]      z_word;

  // Step j consumes step j-1's state, so z of step j is the j-th oldest bit.
  for (genvar j = 0; j < W; j++) begin : g_step
    logic [ALen-1:0] a_in, a_out;
    logic [BLen-1:0] b_in, b_out;
    logic [CLen-1:0] c_in, c_out;
    if (j == 0) begin : g_first
      assign a_in = a_q;
      assign b_in = b_q;
      assign c_in = c_q;
    end else begin : g_chain
      assign a_in = g_step[j-1].a_out;
      assign b_in = g_step[j-1].b_out;
      assign c_in = g_step[j-1].c_out;
    end
    trivium_step u_step (
      .a_i (a_in),
      .b_i (b_in),
      .c_i (c_in),
      .a_o (a_out),
      .b_o (b_out),
      .c_o (c_out),
      .z_o (z_word[j])
    );
  end

  assign a_adv = g_step[W-1].a_out;
  assign b_adv = g_step[W-1].b_out;
  assign c_adv = g_step[W-1].c_out;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    ks_valid_d = ks_valid_q;
    ks_data_d  = ks_data_q;
    // A load restarts from any state and drops any pending word, even one being accepted.
    if (load) begin
      state_d    = StWarmup;
      a_d        = {{(ALen - KeyLen){1'b0}}, key};
      b_d        = {{(BLen - KeyLen){1'b0}}, iv};
      c_d        = {3'b111, {(CLen - 3){1'b0}}};
      cnt_d      = '0;
      ks_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StWarmup: begin
          a_d   = a_adv;
          b_d   = b_adv;
          c_d   = c_adv;
          cnt_d = cnt_q + CntOne;
          if (cnt_q == CntLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!ks_valid_q || ks_ready) begin
            a_d        = a_adv;
            b_d        = b_adv;
            c_d        = c_adv;
            ks_valid_d = 1'b1;
            ks_data_d  = z_word;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      cnt_q      <= '0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      ks_valid_q <= ks_valid_d;
      ks_data_q  <= ks_data_d;
    end
  end

  assign busy     = (state_q == StWarmup);
  assign ks_valid = ks_valid_q;
  assign ks_data  = ks_data_q;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Directed bench for trivium_keystream_gen: four widths side by side against a
// bit-serial Trivium reference written in the classic s1..s288 numbering.
module tb_trivium_keystream_gen;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [79:0] key, iv;

  logic        busy1, busy8, busy64, busy16;
  logic        vld1, vld8, vld64, vld16;
  logic        rdy1, rdy8, rdy64, rdy16;
  logic [0:0]  dat1;
  logic [7:0]  dat8;
  logic [63:0] dat64;
  logic [15:0] dat16;

  int          checks, errors;
  int          bc1, bc8, bc64, bc16;
  int          fv1, fv8, fv64, fv16;
  int          n1, n8, n16, n64;
  int          quiet;
  logic [63:0] got1, got8, got16, got64;
  logic [63:0] gold, gold16;

  localparam logic [79:0] K1 = 80'h0123456789abcdef1357;
  localparam logic [79:0] V1 = 80'hfedcba98765432102468;
  localparam logic [79:0] K2 = 80'h5a5a_0f0f_c3c3_9669_1234;
  localparam logic [79:0] V2 = 80'h0000_ffff_8001_7ffe_abcd;

  trivium_keystream_gen #(.W(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .iv(iv),
    .busy(busy1), .ks_valid(vld1), .ks_ready(rdy1), .ks_data(dat1)
  );
  trivium_keystream_gen #(.W(8)) u_w8 (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .iv(iv),
    .busy(busy8), .ks_valid(vld8), .ks_ready(rdy8), .ks_data(dat8)
  );
  trivium_keystream_gen #(.W(64)) u_w64 (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .iv(iv),
    .busy(busy64), .ks_valid(vld64), .ks_ready(rdy64), .ks_data(dat64)
  );
  trivium_keystream_gen #(.W(16), .WARMUP_BITS(64)) u_w16 (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .iv(iv),
    .busy(busy16), .ks_valid(vld16), .ks_ready(rdy16), .ks_data(dat16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference Trivium: s1..s93 = A, s94..s177 = B, s178..s288 = C.
  task automatic make_gold(input logic [79:0] k, input logic [79:0] v, input int warm,
                           output logic [63:0] g);
    logic [288:1] s;
    logic t1, t2, t3;
    s = '0;
    for (int i = 0; i < 80; i++) begin
      s[i+1]  = k[i];
      s[i+94] = v[i];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    g = '0;
    for (int n = 0; n < warm + 64; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (n >= warm) g[n-warm] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      s = {s[287:178], t2, s[176:94], t1, s[92:1], t3};
    end
  endtask

  // Sample c = 1 is the cycle right after the load edge.
  task automatic run_stream(input int nc);
    bc1 = 0; bc8 = 0; bc64 = 0; bc16 = 0;
    fv1 = 0; fv8 = 0; fv64 = 0; fv16 = 0;
    n1 = 0; n8 = 0; n16 = 0; n64 = 0;
    got1 = '0; got8 = '0; got16 = '0; got64 = '0;
    for (int c = 1; c <= nc; c++) begin
      if (busy1) bc1++;
      if (busy8) bc8++;
      if (busy64) bc64++;
      if (busy16) bc16++;
      if (vld1 && fv1 == 0) fv1 = c;
      if (vld8 && fv8 == 0) fv8 = c;
      if (vld64 && fv64 == 0) fv64 = c;
      if (vld16 && fv16 == 0) fv16 = c;
      if (vld1 && rdy1 && n1 < 64) begin got1[n1] = dat1[0]; n1++; end
      if (vld8 && rdy8 && n8 < 8) begin got8[n8*8 +: 8] = dat8; n8++; end
      if (vld16 && rdy16 && n16 < 4) begin got16[n16*16 +: 16] = dat16; n16++; end
      if (vld64 && rdy64 && n64 < 1) begin got64 = dat64; n64++; end
      tick();
    end
  endtask

  task automatic check_all(input string tag, input bit chk8);
    chk({tag, "_busy_w1"}, 64'(bc1), 64'd1152);
    chk({tag, "_busy_w8"}, 64'(bc8), 64'd144);
    chk({tag, "_busy_w64"}, 64'(bc64), 64'd18);
    chk({tag, "_busy_w16"}, 64'(bc16), 64'd4);
    chk({tag, "_first_valid_w1"}, 64'(fv1), 64'd1154);
    chk({tag, "_first_valid_w8"}, 64'(fv8), 64'd146);
    chk({tag, "_first_valid_w64"}, 64'(fv64), 64'd20);
    chk({tag, "_first_valid_w16"}, 64'(fv16), 64'd6);
    chk({tag, "_stream_w1"}, got1, gold);
    chk({tag, "_stream_w64"}, got64, gold);
    chk({tag, "_stream_w16"}, got16, gold16);
    if (chk8) chk({tag, "_stream_w8"}, got8, gold);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    load = 1'b0;
    key = '0;
    iv = '0;
    rdy1 = 1'b1;
    rdy8 = 1'b0;
    rdy64 = 1'b1;
    rdy16 = 1'b1;
    tick();
    tick();

    // Reset wins over a simultaneous load.
    load = 1'b1;
    tick();
    chk("rst_busy_w1", busy1, 1'b0);
    chk("rst_busy_w8", busy8, 1'b0);
    chk("rst_busy_w64", busy64, 1'b0);
    chk("rst_busy_w16", busy16, 1'b0);
    chk("rst_valid_w8", vld8, 1'b0);
    chk("rst_data_w8", dat8, 8'h00);
    chk("rst_data_w64", dat64, 64'h0);
    load = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("idle_busy_w8", busy8, 1'b0);
    chk("idle_valid_w8", vld8, 1'b0);

    // All-zero key/iv; W=8 is left unacknowledged to build a stall.
    make_gold(80'h0, 80'h0, 1152, gold);
    make_gold(80'h0, 80'h0, 64, gold16);
    load = 1'b1;
    tick();
    load = 1'b0;
    run_stream(1230);
    check_all("k0", 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid_w8", vld8, 1'b1);
      chk("stall_data_w8", dat8, gold[7:0]);
      tick();
    end
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    chk("next_word_w8", dat8, gold[15:8]);
    tick();
    chk("hold_word_w8", dat8, gold[15:8]);

    // Restart while W=8 holds a pending word and W=1 is mid-handshake.
    key = K1;
    iv = V1;
    make_gold(K1, V1, 1152, gold);
    make_gold(K1, V1, 64, gold16);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("restart_valid_w8", vld8, 1'b0);
    chk("restart_busy_w8", busy8, 1'b1);
    chk("restart_valid_w1", vld1, 1'b0);
    rdy8 = 1'b1;
    run_stream(1230);
    check_all("k1", 1'b1);

    // Reset at warm-up cycle 500 of W=1 (W=8/16/64 are already running).
    key = K2;
    iv = V2;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 1; i < 500; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_busy_w1", busy1, 1'b0);
    chk("abort_valid_w8", vld8, 1'b0);
    chk("abort_valid_w64", vld64, 1'b0);
    chk("abort_data_w16", dat16, 16'h0);
    quiet = 0;
    for (int i = 0; i < 1300; i++) begin
      if (busy1 | busy8 | busy64 | busy16 | vld1 | vld8 | vld64 | vld16) quiet++;
      tick();
    end
    chk("abort_quiet", 64'(quiet), 64'd0);
    make_gold(K2, V2, 1152, gold);
    make_gold(K2, V2, 64, gold16);
    load = 1'b1;
    tick();
    load = 1'b0;
    run_stream(1230);
    check_all("k2", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
